// File: rtl/dac_write_module.sv
// Write-only SPI master for an external DAC: MSB-first mode-0 frames framed by cs_n_o,
// followed by an optional LDAC strobe and an idle gap before the next word is accepted.
`timescale 1ns/1ps

module dac_write_module #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned LDAC_CYC   = 2,
    parameter int unsigned GAP_CYC    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic                  sck_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    output logic                  ldac_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int unsigned CntW = 16;
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BitLast   = CntW'(2 * CLK_DIV - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
    localparam logic [CntW-1:0] LdacLast  = CntW'(LDAC_CYC - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYC - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StLdac, StGap} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cyc_q;
    logic [BitW-1:0]       bit_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  finish;

    assign shreg_next = shreg_q << 1;

    // Last cycle of the frame, wherever the zero-length LDAC/GAP states collapse it to.
    always_comb begin
        finish = 1'b0;
        if (state_q == StHold && cyc_q == HoldLast && LDAC_CYC == 0 && GAP_CYC == 0) begin
            finish = 1'b1;
        end
        if (state_q == StLdac && cyc_q == LdacLast && GAP_CYC == 0) begin
            finish = 1'b1;
        end
        if (state_q == StGap && cyc_q == GapLast) begin
            finish = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            data_ready_o <= 1'b0;
            sck_o        <= 1'b0;
            cs_n_o       <= 1'b1;
            mosi_o       <= 1'b0;
            ldac_n_o     <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    data_ready_o <= 1'b1;
                    if (data_valid_i && data_ready_o) begin
                        shreg_q      <= data_i;
                        cs_n_o       <= 1'b0;
                        mosi_o       <= data_i[DATA_WIDTH-1];
                        data_ready_o <= 1'b0;
                        busy_o       <= 1'b1;
                        cyc_q        <= '0;
                        bit_q        <= '0;
                        state_q      <= StSetup;
                    end
                end
                StSetup: begin
                    if (cyc_q == SetupLast) begin
                        cyc_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                StShift: begin
                    // mosi_o only moves on the edge that drops sck_o, so it is stable while high.
                    if (cyc_q == BitLast) begin
                        sck_o <= 1'b0;
                        cyc_q <= '0;
                        if (bit_q == LastBit) begin
                            state_q <= StHold;
                        end else begin
                            bit_q   <= bit_q + BitW'(1);
                            shreg_q <= shreg_next;
                            mosi_o  <= shreg_next[DATA_WIDTH-1];
                        end
                    end else begin
                        if (cyc_q == HalfLast) begin
                            sck_o <= 1'b1;
                        end
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (cyc_q == HoldLast) begin
                        cs_n_o <= 1'b1;
                        mosi_o <= 1'b0;
                        cyc_q  <= '0;
                        if (LDAC_CYC != 0) begin
                            ldac_n_o <= 1'b0;
                            state_q  <= StLdac;
                        end else begin
                            state_q <= StGap;
                        end
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                StLdac: begin
                    if (cyc_q == LdacLast) begin
                        ldac_n_o <= 1'b1;
                        cyc_q    <= '0;
                        state_q  <= StGap;
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                StGap: begin
                    cyc_q <= cyc_q + CntW'(1);
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (finish) begin
                data_ready_o <= 1'b1;
                busy_o       <= 1'b0;
                done_o       <= 1'b1;
                frame_cnt_o  <= frame_cnt_o + 16'd1;
                cyc_q        <= '0;
                state_q      <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_dac_write_module.sv
// Bench for dac_write_module: one default instance and one with CLK_DIV=1, no LDAC, no gap.
`timescale 1ns/1ps

module tb_dac_write_module;

    localparam int DW = 16;
    localparam int CD_A = 4, SU_A = 2, HD_A = 2, LD_A = 2, GP_A = 4;
    localparam int CD_B = 1, SU_B = 2, HD_B = 2, LD_B = 0, GP_B = 0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       valid, ready, sck, cs_n, mosi, ldac_n, busy, done;
    logic [1:0][15:0] din, fcnt;

    always #5 clk = ~clk;

    dac_write_module #(
        .DATA_WIDTH(DW), .CLK_DIV(CD_A), .CS_SETUP(SU_A), .CS_HOLD(HD_A),
        .LDAC_CYC(LD_A), .GAP_CYC(GP_A)
    ) dut_a (
        .clk_i(clk), .rst(rst), .data_i(din[0]), .data_valid_i(valid[0]),
        .data_ready_o(ready[0]), .sck_o(sck[0]), .cs_n_o(cs_n[0]), .mosi_o(mosi[0]),
        .ldac_n_o(ldac_n[0]), .busy_o(busy[0]), .done_o(done[0]), .frame_cnt_o(fcnt[0])
    );

    dac_write_module #(
        .DATA_WIDTH(DW), .CLK_DIV(CD_B), .CS_SETUP(SU_B), .CS_HOLD(HD_B),
        .LDAC_CYC(LD_B), .GAP_CYC(GP_B)
    ) dut_b (
        .clk_i(clk), .rst(rst), .data_i(din[1]), .data_valid_i(valid[1]),
        .data_ready_o(ready[1]), .sck_o(sck[1]), .cs_n_o(cs_n[1]), .mosi_o(mosi[1]),
        .ldac_n_o(ldac_n[1]), .busy_o(busy[1]), .done_o(done[1]), .frame_cnt_o(fcnt[1])
    );

    function automatic int p_cd(int s); return (s == 0) ? CD_A : CD_B; endfunction
    function automatic int p_ld(int s); return (s == 0) ? LD_A : LD_B; endfunction
    function automatic int p_gp(int s); return (s == 0) ? GP_A : GP_B; endfunction
    function automatic int exp_cs_low(int s);
        return (s == 0) ? SU_A + 2 * CD_A * DW + HD_A : SU_B + 2 * CD_B * DW + HD_B;
    endfunction
    function automatic int exp_latency(int s);
        return exp_cs_low(s) + p_ld(s) + p_gp(s);
    endfunction

    int errors = 0;
    int checks = 0;
    int cur_dut = 0;
    int exp_cnt [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s (dut %0d): got %0d (0x%0h), required %0d (0x%0h)",
                     name, cur_dut, got, got, req, req);
        end
    endtask

    // Observations of the most recent frame.
    logic [15:0] r_got;
    int r_rises, r_cs_low, r_ldac_low, r_ldac_first, r_tail, r_period, r_lat, r_waits;
    bit r_rdy_bad, r_ok, r_busy_acc;

    task automatic run_frame(input int s, input logic [15:0] word, input bit hold,
                             input logic [15:0] next_word, input int chg_at,
                             input logic [15:0] chg_word);
        int first_rise, t_csrise;
        logic prev_sck;
        r_got = '0; r_rises = 0; r_cs_low = 0; r_ldac_low = 0; r_ldac_first = -1;
        r_tail = 0; r_period = -1; r_lat = -1; r_waits = 0; r_rdy_bad = 0; r_ok = 0;
        first_rise = 0; t_csrise = -1;
        cur_dut = s;
        din[s] = word;
        valid[s] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (cs_n[s] == 1'b0) break;
            r_waits++;
        end
        if (cs_n[s] != 1'b0) begin
            chk("accept_timeout", 32'(r_waits), 32'd0);
            valid[s] = 1'b0;
            return;
        end
        if (!hold) valid[s] = 1'b0;
        r_busy_acc = busy[s];
        r_cs_low = 1;
        prev_sck = sck[s];
        for (int t = 1; t < 1000; t++) begin
            @(posedge clk); #1;
            if (t == chg_at) din[s] = chg_word;
            if (sck[s] && !prev_sck) begin
                if (r_rises == 0) first_rise = t;
                else if (r_rises == 1) r_period = t - first_rise;
                r_got = {r_got[14:0], mosi[s]};
                r_rises++;
            end
            prev_sck = sck[s];
            if (!cs_n[s]) r_cs_low++;
            else begin
                if (t_csrise < 0) t_csrise = t;
                r_tail++;
            end
            if (!ldac_n[s]) begin
                r_ldac_low++;
                if (r_ldac_first < 0) r_ldac_first = t - t_csrise;
            end
            if (done[s]) begin
                r_lat = t;
                r_ok = 1;
                if (hold) din[s] = next_word;
                break;
            end
            if (ready[s]) r_rdy_bad = 1;
        end
    endtask

    task automatic check_frame(input int s, input logic [15:0] exp_word, input int exp_lat,
                               input bit hold);
        cur_dut = s;
        chk("frame_done", 32'(r_ok), 32'd1);
        chk("serial_bits", 32'(r_got), 32'(exp_word));
        chk("sck_rises", 32'(r_rises), 32'(DW));
        chk("sck_period", 32'(r_period), 32'(2 * p_cd(s)));
        chk("cs_low_cycles", 32'(r_cs_low), 32'(exp_cs_low(s)));
        chk("ldac_low_cycles", 32'(r_ldac_low), 32'(p_ld(s)));
        chk("ldac_start", 32'(r_ldac_first), (p_ld(s) != 0) ? 32'd0 : 32'hFFFF_FFFF);
        chk("accept_to_done", 32'(r_lat), 32'(exp_lat));
        chk("ready_low_in_frame", 32'(r_rdy_bad), 32'd0);
        chk("busy_at_accept", 32'(r_busy_acc), 32'd1);
        exp_cnt[s] = (exp_cnt[s] + 1) % 65536;
        chk("frame_cnt", 32'(fcnt[s]), 32'(exp_cnt[s]));
        if (!hold) begin
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done[s]), 32'd0);
            chk("ready_after", 32'(ready[s]), 32'd1);
            chk("busy_after", 32'(busy[s]), 32'd0);
            chk("cs_n_idle", 32'(cs_n[s]), 32'd1);
        end
    endtask

    task automatic check_reset_values(input int s, input string tag);
        cur_dut = s;
        chk({tag, "_ready"}, 32'(ready[s]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[s]), 32'd0);
        chk({tag, "_done"}, 32'(done[s]), 32'd0);
        chk({tag, "_fcnt"}, 32'(fcnt[s]), 32'd0);
        chk({tag, "_sck"}, 32'(sck[s]), 32'd0);
        chk({tag, "_cs_n"}, 32'(cs_n[s]), 32'd1);
        chk({tag, "_mosi"}, 32'(mosi[s]), 32'd0);
        chk({tag, "_ldac_n"}, 32'(ldac_n[s]), 32'd1);
    endtask

    typedef struct {
        int          s;
        logic [15:0] word;
        int          chg_at;
        logic [15:0] chg_word;
        logic [15:0] exp_word;
        int          exp_lat;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int tail;
        int rises;
        logic prev;
        valid = '0;
        din = '0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;

        tbl[0] = '{0, 16'hA5C3, 0, 16'h0000, 16'hA5C3, 138};
        tbl[1] = '{0, 16'h8000, 40, 16'h1234, 16'h8000, 138};
        tbl[2] = '{1, 16'hA5C3, 0, 16'h0000, 16'hA5C3, 36};
        tbl[3] = '{1, 16'h8000, 10, 16'h1234, 16'h8000, 36};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values(0, "reset");
        check_reset_values(1, "reset");
        rst = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            cur_dut = s;
            chk("ready_after_reset", 32'(ready[s]), 32'd1);
        end

        foreach (tbl[i]) begin
            run_frame(tbl[i].s, tbl[i].word, 1'b0, 16'h0, tbl[i].chg_at, tbl[i].chg_word);
            check_frame(tbl[i].s, tbl[i].exp_word, tbl[i].exp_lat, 1'b0);
        end

        // Back-to-back: valid stays high, second word must go on the done cycle.
        for (int s = 0; s < 2; s++) begin
            run_frame(s, 16'h0001, 1'b1, 16'hFFFF, 0, 16'h0);
            check_frame(s, 16'h0001, exp_latency(s), 1'b1);
            tail = r_tail;
            run_frame(s, 16'hFFFF, 1'b0, 16'h0, 0, 16'h0);
            chk("b2b_accept_on_done", 32'(r_waits), 32'd0);
            chk("b2b_cs_high_gap", 32'(tail + r_waits), 32'(p_ld(s) + p_gp(s) + 1));
            check_frame(s, 16'hFFFF, exp_latency(s), 1'b0);
        end

        // Asynchronous reset in the middle of bit 7 of 0xFFFF.
        cur_dut = 0;
        din[0] = 16'hFFFF;
        valid[0] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (cs_n[0] == 1'b0) break;
        end
        valid[0] = 1'b0;
        rises = 0;
        prev = sck[0];
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (sck[0] && !prev) rises++;
            prev = sck[0];
            if (rises == 8) break;
        end
        @(posedge clk); #1;
        chk("pre_rst_cs_n", 32'(cs_n[0]), 32'd0);
        chk("pre_rst_sck", 32'(sck[0]), 32'd1);
        chk("pre_rst_mosi", 32'(mosi[0]), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values(0, "midframe_rst");
        check_reset_values(1, "midframe_rst");
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(0, 16'h5555, 1'b0, 16'h0, 0, 16'h0);
        check_frame(0, 16'h5555, 138, 1'b0);

        // Counter wrap from 0xFFFF.
        force dut_a.frame_cnt_o = 16'hFFFF;
        @(posedge clk); #1;
        release dut_a.frame_cnt_o;
        exp_cnt[0] = 16'hFFFF;
        run_frame(0, 16'h3C3C, 1'b0, 16'h0, 0, 16'h0);
        check_frame(0, 16'h3C3C, 138, 1'b0);

        // Random words, random mid-frame data_i changes.
        for (int i = 0; i < 8; i++) begin
            int s;
            logic [15:0] w;
            s = int'($urandom_range(1, 0));
            w = 16'($urandom);
            run_frame(s, w, 1'b0, 16'h0, int'($urandom_range(exp_cs_low(s) - 4, 1)),
                      16'($urandom));
            check_frame(s, w, exp_latency(s), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
